// File: rtl/ahb_burst_master_if.sv
// Local command/data handshakes and the AHB-Lite master bus of ahb_burst_master.
// The master modport is the sequencer's view; the slave modport is the far side.
interface ahb_burst_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_burst;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        cmd_err;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_burst, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid,
           HRDATA, HREADY, HRESP,
    output cmd_ready, cmd_err, wdata_ready, rdata, rdata_valid, done, err,
           HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_burst, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid,
           HRDATA, HREADY, HRESP,
    input  cmd_ready, cmd_err, wdata_ready, rdata, rdata_valid, done, err,
           HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA
  );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst transfer sequencer: takes one burst command at a time and runs
// the address/data-phase pipeline (NONSEQ/SEQ/BUSY/IDLE, INCR and WRAP
// addressing, wait states, two-cycle ERROR response).
// wdata_valid follows valid/ready rules: once high it stays high until wdata_ready,
// which keeps a stalled write transfer stable while HREADY is low.
module ahb_burst_master #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0400,
  parameter int unsigned MAX_INCR  = 16
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb_burst_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;
  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_t;

  state_t      state_q, state_d;
  htrans_t     htrans;
  logic [31:0] haddr_q, hwdata_q, rdata_q;
  logic [2:0]  hburst_q;
  logic        hwrite_q;
  logic [4:0]  beats_left_q, cmd_beats;
  logic        dp_active_q, dp_write_q;
  logic        rdata_valid_q, done_q, err_q, cmd_err_q;
  logic        accept, reject, xfer, finish, err_first, last_beat;
  logic        incr_type, len_bad, crosses_1k;

  // Next beat address: an all-ones mask degenerates to a plain +4 for INCR types.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] burst);
    logic [31:0] m;
    unique case (burst)
      3'd2:    m = 32'h0000_000F;
      3'd4:    m = 32'h0000_001F;
      3'd6:    m = 32'h0000_003F;
      default: m = 32'hFFFF_FFFF;
    endcase
    return (a & ~m) | ((a + 32'd4) & m);
  endfunction

  // Decode beat count and legality of the offered command.
  always_comb begin
    unique case (bus.cmd_burst)
      3'd0:       cmd_beats = 5'd1;
      3'd1:       cmd_beats = bus.cmd_len;
      3'd2, 3'd3: cmd_beats = 5'd4;
      3'd4, 3'd5: cmd_beats = 5'd8;
      default:    cmd_beats = 5'd16;
    endcase
    incr_type  = (bus.cmd_burst == 3'd0) || bus.cmd_burst[0];
    len_bad    = (bus.cmd_burst == 3'd1) &&
                 ((bus.cmd_len == 5'd0) || ({27'd0, bus.cmd_len} > MAX_INCR));
    crosses_1k = incr_type && (({2'b00, bus.cmd_addr[9:2]} + {5'd0, cmd_beats}) > 10'd256);
  end

  assign last_beat = (beats_left_q == 5'd1);
  // First ERROR cycle: the data phase in flight reports ERROR while stalling.
  assign err_first = dp_active_q && bus.HRESP && !bus.HREADY;

  // Next-state and transfer-type decode for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    htrans  = TR_IDLE;
    accept  = 1'b0;
    reject  = 1'b0;
    xfer    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (len_bad || crosses_1k) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (!hwrite_q || bus.wdata_valid) begin
          htrans = TR_NONSEQ;
          if (bus.HREADY) begin
            xfer    = 1'b1;
            state_d = last_beat ? S_LAST : S_BURST;
          end
        end
      end
      S_BURST: begin
        if (err_first) begin
          state_d = S_ERR;
        end else if (hwrite_q && !bus.wdata_valid) begin
          htrans = TR_BUSY;
        end else begin
          htrans = TR_SEQ;
          if (bus.HREADY) begin
            xfer    = 1'b1;
            state_d = last_beat ? S_LAST : S_BURST;
          end
        end
      end
      S_LAST: begin
        if (err_first) begin
          state_d = S_ERR;
        end else if (bus.HREADY) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (bus.HREADY) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Address/control, write data, data-phase tracking and local-side pulses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q       <= BASE_ADDR;
      hburst_q      <= 3'd0;
      hwrite_q      <= 1'b0;
      beats_left_q  <= 5'd0;
      hwdata_q      <= 32'd0;
      dp_active_q   <= 1'b0;
      dp_write_q    <= 1'b0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      if (accept) begin
        haddr_q      <= bus.cmd_addr & ~32'h3;
        hburst_q     <= bus.cmd_burst;
        hwrite_q     <= bus.cmd_write;
        beats_left_q <= cmd_beats;
      end else if (xfer) begin
        beats_left_q <= beats_left_q - 5'd1;
        if (!last_beat) haddr_q <= next_addr(haddr_q, hburst_q);
      end else if (finish) begin
        haddr_q  <= BASE_ADDR;
        hwrite_q <= 1'b0;
      end
      if (xfer && hwrite_q) hwdata_q <= bus.wdata;
      // A completed address phase opens a data phase; ERROR cancels it outright.
      if (err_first) begin
        dp_active_q <= 1'b0;
      end else if (bus.HREADY) begin
        dp_active_q <= xfer;
        dp_write_q  <= hwrite_q;
      end
      rdata_valid_q <= dp_active_q && !dp_write_q && bus.HREADY && !bus.HRESP;
      if (dp_active_q && !dp_write_q && bus.HREADY && !bus.HRESP) rdata_q <= bus.HRDATA;
      done_q    <= finish;
      err_q     <= finish && (state_q == S_ERR);
      cmd_err_q <= reject;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.cmd_err     = cmd_err_q;
  assign bus.wdata_ready = xfer && hwrite_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.HADDR       = haddr_q;
  assign bus.HTRANS      = htrans;
  assign bus.HWRITE      = hwrite_q;
  assign bus.HBURST      = hburst_q;
  assign bus.HSIZE       = 3'b010;
  assign bus.HWDATA      = hwdata_q;

endmodule
